// File: rtl/toy_physical_regfile_bank.sv
// toy_physical_regfile_bank
// Physical register file bank for the issue stage. Each entry holds a data
// word and a ready bit. The bank has these ports:
//   - rename allocate ports: clear the ready bit of an entry
//   - writeback ports: write data and set the ready bit
//   - issue read ports: read data and ready combinationally
// In INT mode (MODE == 0) entry 0 always reads as zero and ready.
// ready_cnt is a registered popcount of the ready vector for the next state.
// Optional feature macro: TOY_PRF_WR_BYPASS_EN. When it is defined, writeback
// data is forwarded to read ports that target the same entry in the same cycle.
module toy_physical_regfile_bank #(
    parameter int REG_WIDTH   = 64,
    parameter int NUM_ENTRY   = 96,
    parameter int NUM_WR_PORT = 4,
    parameter int NUM_RD_PORT = 8,
    parameter int NUM_ALLOC   = 4,
    parameter int MODE        = 0,
    localparam int IDX_W      = $clog2(NUM_ENTRY),
    localparam int CNT_W      = $clog2(NUM_ENTRY + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_ALLOC-1:0]   alloc_vld,
    input  logic [IDX_W-1:0]       alloc_idx [NUM_ALLOC],
    input  logic [NUM_WR_PORT-1:0] wr_en,
    input  logic [IDX_W-1:0]       wr_idx    [NUM_WR_PORT],
    input  logic [REG_WIDTH-1:0]   wr_data   [NUM_WR_PORT],
    input  logic [IDX_W-1:0]       rd_idx    [NUM_RD_PORT],
    output logic [REG_WIDTH-1:0]   rd_data   [NUM_RD_PORT],
    output logic [NUM_RD_PORT-1:0] rd_ready,
    output logic [CNT_W-1:0]       ready_cnt
);

    localparam logic [IDX_W:0]     NUM_ENTRY_L = (IDX_W + 1)'(NUM_ENTRY);
    localparam logic [CNT_W-1:0]   CNT_RST     = CNT_W'(NUM_ENTRY);
    localparam bit                 INT_MODE    = (MODE == 32'sd0);
    localparam logic [IDX_W-1:0]   IDX_ZERO    = {IDX_W{1'b0}};

    logic [REG_WIDTH-1:0] data_r      [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] ready_r;
    logic [CNT_W-1:0]     ready_cnt_r;

    logic [REG_WIDTH-1:0] data_nxt_s  [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] ready_nxt_s;
    logic [CNT_W-1:0]     cnt_nxt_s;

`ifdef TOY_PRF_WR_BYPASS_EN
    logic [NUM_RD_PORT-1:0] byp_hit_s;
`endif

    // Index exists in the bank (the upper encodings of the index field are unused)
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < NUM_ENTRY_L);
    endfunction

    // Index names an entry whose state can change (entry 0 is constant in INT mode)
    function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
        return idx_valid(idx) && !(INT_MODE && (idx == IDX_ZERO));
    endfunction

    // Number of set bits in the ready vector
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRY-1:0] vec);
        logic [CNT_W-1:0] sum;
        sum = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_ENTRY; i++) begin
            sum = sum + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return sum;
    endfunction

    // Next-state bank: writes apply in ascending port order so the highest port wins,
    // then allocates clear ready so an allocate beats a same-cycle write
    always_comb begin
        data_nxt_s  = data_r;
        ready_nxt_s = ready_r;
        for (int p = 0; p < NUM_WR_PORT; p++) begin
            if (wr_en[p] && idx_writable(wr_idx[p])) begin
                data_nxt_s[wr_idx[p]]  = wr_data[p];
                ready_nxt_s[wr_idx[p]] = 1'b1;
            end else begin
                // idle, out-of-range or hardwired target: no state change
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_vld[a] && idx_writable(alloc_idx[a])) begin
                ready_nxt_s[alloc_idx[a]] = 1'b0;
            end else begin
                // idle, out-of-range or hardwired target: no state change
            end
        end
        if (INT_MODE) begin
            data_nxt_s[0]  = {REG_WIDTH{1'b0}};
            ready_nxt_s[0] = 1'b1;
        end else begin
            // FP mode: entry 0 is an ordinary entry
        end
        cnt_nxt_s = popcount(ready_nxt_s);
    end

    // Bank state and ready count registers; reset leaves every entry zero and ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r      <= '{default: {REG_WIDTH{1'b0}}};
            ready_r     <= {NUM_ENTRY{1'b1}};
            ready_cnt_r <= CNT_RST;
        end else begin
            data_r      <= data_nxt_s;
            ready_r     <= ready_nxt_s;
            ready_cnt_r <= cnt_nxt_s;
        end
    end

    assign ready_cnt = ready_cnt_r;

    // Issue read ports: registered state, hardwired entry 0, optional writeback forwarding
    always_comb begin
`ifdef TOY_PRF_WR_BYPASS_EN
        byp_hit_s = {NUM_RD_PORT{1'b0}};
`endif
        for (int r = 0; r < NUM_RD_PORT; r++) begin
            rd_data[r]  = {REG_WIDTH{1'b0}};
            rd_ready[r] = 1'b0;
            if (!idx_valid(rd_idx[r])) begin
                // nonexistent entry reads as zero and not ready
            end else if (INT_MODE && (rd_idx[r] == IDX_ZERO)) begin
                rd_ready[r] = 1'b1;
            end else begin
                rd_data[r]  = data_r[rd_idx[r]];
                rd_ready[r] = ready_r[rd_idx[r]];
`ifdef TOY_PRF_WR_BYPASS_EN
                for (int p = 0; p < NUM_WR_PORT; p++) begin
                    if (wr_en[p] && (wr_idx[p] == rd_idx[r])) begin
                        rd_data[r]   = wr_data[p];
                        rd_ready[r]  = 1'b1;
                        byp_hit_s[r] = 1'b1;
                    end else begin
                        // this port does not target the read entry
                    end
                end
                for (int a = 0; a < NUM_ALLOC; a++) begin
                    if (byp_hit_s[r] && alloc_vld[a] && (alloc_idx[a] == rd_idx[r])) begin
                        rd_ready[r] = 1'b0;
                    end else begin
                        // no allocate competes with the forwarded write
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_toy_physical_regfile_bank.sv
// Directed testbench for toy_physical_regfile_bank.
// Two instances share the same stimulus: u_int (MODE 0) and u_fp (MODE 1).
module tb_toy_physical_regfile_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alloc_vld;
    logic [6:0]  alloc_idx [4];
    logic [3:0]  wr_en;
    logic [6:0]  wr_idx    [4];
    logic [63:0] wr_data   [4];
    logic [6:0]  rd_idx    [8];
    logic [63:0] rd_data0  [8];
    logic [63:0] rd_data1  [8];
    logic [7:0]  rd_ready0;
    logic [7:0]  rd_ready1;
    logic [6:0]  cnt0;
    logic [6:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toy_physical_regfile_bank #(.MODE(0)) u_int (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_idx(alloc_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data0), .rd_ready(rd_ready0),
        .ready_cnt(cnt0)
    );

    toy_physical_regfile_bank #(.MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_idx(alloc_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data1), .rd_ready(rd_ready1),
        .ready_cnt(cnt1)
    );

    task automatic clear_inputs();
        alloc_vld = 4'b0;
        wr_en     = 4'b0;
        for (int i = 0; i < 4; i++) begin
            alloc_idx[i] = 7'd0;
            wr_idx[i]    = 7'd0;
            wr_data[i]   = 64'd0;
        end
        for (int i = 0; i < 8; i++) rd_idx[i] = 7'd0;
    endtask

    // Advance one clock and settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_idx[0] = 7'd5; rd_idx[1] = 7'd100; rd_idx[2] = 7'd0;
        #1;
        checks++; if (rd_data0[0] !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rd_data0[0]); end
        checks++; if (rd_ready0[0] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rd_ready0[0]); end
        checks++; if (cnt0 !== 7'd96) begin failures++; $display("FAIL reset_cnt got=%0d exp=96", cnt0); end
        checks++; if (rd_data0[1] !== 64'd0 || rd_ready0[1] !== 1'b0) begin failures++; $display("FAIL oor_read got=%h/%b exp=0/0", rd_data0[1], rd_ready0[1]); end
        checks++; if (rd_data0[2] !== 64'd0 || rd_ready0[2] !== 1'b1) begin failures++; $display("FAIL reset_idx0 got=%h/%b exp=0/1", rd_data0[2], rd_ready0[2]); end
    endtask

    task automatic test_alloc_write();
        rd_idx[0] = 7'd7;
        alloc_vld[0] = 1'b1; alloc_idx[0] = 7'd7;
        tick();
        alloc_vld = 4'b0;
        #1;
        checks++; if (rd_ready0[0] !== 1'b0) begin failures++; $display("FAIL alloc_ready got=%b exp=0", rd_ready0[0]); end
        checks++; if (cnt0 !== 7'd95) begin failures++; $display("FAIL alloc_cnt got=%0d exp=95", cnt0); end
        checks++; if (rd_data0[0] !== 64'd0) begin failures++; $display("FAIL alloc_data got=%h exp=0", rd_data0[0]); end
        tick();
        wr_en[1] = 1'b1; wr_idx[1] = 7'd7; wr_data[1] = 64'hDEAD;
        tick();
        wr_en = 4'b0;
        #1;
        checks++; if (rd_data0[0] !== 64'hDEAD) begin failures++; $display("FAIL write_data got=%h exp=dead", rd_data0[0]); end
        checks++; if (rd_ready0[0] !== 1'b1) begin failures++; $display("FAIL write_ready got=%b exp=1", rd_ready0[0]); end
        checks++; if (cnt0 !== 7'd96) begin failures++; $display("FAIL write_cnt got=%0d exp=96", cnt0); end
    endtask

    task automatic test_collision();
        rd_idx[3] = 7'd9;
        wr_en = 4'b1001;
        wr_idx[0] = 7'd9; wr_data[0] = 64'h11;
        wr_idx[3] = 7'd9; wr_data[3] = 64'h33;
        tick();
        wr_en = 4'b0;
        #1;
        checks++; if (rd_data0[3] !== 64'h33) begin failures++; $display("FAIL collision_data got=%h exp=33", rd_data0[3]); end
        checks++; if (rd_ready0[3] !== 1'b1) begin failures++; $display("FAIL collision_ready got=%b exp=1", rd_ready0[3]); end
    endtask

    task automatic test_entry0();
        rd_idx[4] = 7'd0;
        wr_en[1] = 1'b1; wr_idx[1] = 7'd0; wr_data[1] = 64'hFFFF;
        alloc_vld[2] = 1'b1; alloc_idx[2] = 7'd0;
        tick();
        wr_en = 4'b0; alloc_vld = 4'b0;
        #1;
        checks++; if (rd_data0[4] !== 64'd0 || rd_ready0[4] !== 1'b1) begin failures++; $display("FAIL int_idx0 got=%h/%b exp=0/1", rd_data0[4], rd_ready0[4]); end
        checks++; if (cnt0 !== 7'd96) begin failures++; $display("FAIL int_idx0_cnt got=%0d exp=96", cnt0); end
        checks++; if (rd_data1[4] !== 64'hFFFF || rd_ready1[4] !== 1'b0) begin failures++; $display("FAIL fp_idx0 got=%h/%b exp=ffff/0", rd_data1[4], rd_ready1[4]); end
        checks++; if (cnt1 !== 7'd95) begin failures++; $display("FAIL fp_idx0_cnt got=%0d exp=95", cnt1); end
    endtask

    task automatic test_alloc_write_same();
        rd_idx[5] = 7'd12;
        alloc_vld[3] = 1'b1; alloc_idx[3] = 7'd12;
        wr_en[0] = 1'b1; wr_idx[0] = 7'd12; wr_data[0] = 64'hAB;
        tick();
        wr_en = 4'b0; alloc_vld = 4'b0;
        #1;
        checks++; if (rd_data0[5] !== 64'hAB) begin failures++; $display("FAIL aw_same_data got=%h exp=ab", rd_data0[5]); end
        checks++; if (rd_ready0[5] !== 1'b0) begin failures++; $display("FAIL aw_same_ready got=%b exp=0", rd_ready0[5]); end
        checks++; if (cnt0 !== 7'd95) begin failures++; $display("FAIL aw_same_cnt got=%0d exp=95", cnt0); end
    endtask

    task automatic test_dup_alloc_range();
        rd_idx[6] = 7'd30; rd_idx[7] = 7'd100;
        alloc_vld = 4'b0111;
        alloc_idx[0] = 7'd30; alloc_idx[1] = 7'd30; alloc_idx[2] = 7'd110;
        wr_en[2] = 1'b1; wr_idx[2] = 7'd100; wr_data[2] = 64'h99;
        tick();
        wr_en = 4'b0; alloc_vld = 4'b0;
        #1;
        checks++; if (cnt0 !== 7'd94) begin failures++; $display("FAIL dup_alloc_cnt got=%0d exp=94", cnt0); end
        checks++; if (rd_ready0[6] !== 1'b0) begin failures++; $display("FAIL dup_alloc_ready got=%b exp=0", rd_ready0[6]); end
        checks++; if (rd_data0[7] !== 64'd0 || rd_ready0[7] !== 1'b0) begin failures++; $display("FAIL oor_write got=%h/%b exp=0/0", rd_data0[7], rd_ready0[7]); end
    endtask

    task automatic test_bypass();
        rd_idx[2] = 7'd20;
        wr_en[3] = 1'b1; wr_idx[3] = 7'd20; wr_data[3] = 64'h55;
        #1;
`ifdef TOY_PRF_WR_BYPASS_EN
        checks++; if (rd_data0[2] !== 64'h55 || rd_ready0[2] !== 1'b1) begin failures++; $display("FAIL bypass_same got=%h/%b exp=55/1", rd_data0[2], rd_ready0[2]); end
`else
        checks++; if (rd_data0[2] !== 64'd0 || rd_ready0[2] !== 1'b1) begin failures++; $display("FAIL nobypass_same got=%h/%b exp=0/1", rd_data0[2], rd_ready0[2]); end
`endif
        tick();
        wr_en = 4'b0;
        #1;
        checks++; if (rd_data0[2] !== 64'h55 || rd_ready0[2] !== 1'b1) begin failures++; $display("FAIL bypass_next got=%h/%b exp=55/1", rd_data0[2], rd_ready0[2]); end
    endtask

    task automatic test_back_to_back();
        rd_idx[1] = 7'd40;
        wr_en[0] = 1'b1; wr_idx[0] = 7'd40; wr_data[0] = 64'h1;
        tick();
        wr_data[0] = 64'h2;
        #1;
        checks++; if (rd_data0[1] !== 64'h1) begin failures++; $display("FAIL b2b_first got=%h exp=1", rd_data0[1]); end
        tick();
        wr_en = 4'b0;
        #1;
        checks++; if (rd_data0[1] !== 64'h2) begin failures++; $display("FAIL b2b_second got=%h exp=2", rd_data0[1]); end
        checks++; if (cnt0 !== 7'd94) begin failures++; $display("FAIL b2b_cnt got=%0d exp=94", cnt0); end
    endtask

    task automatic test_reset_mid_write();
        rd_idx[0] = 7'd50; rd_idx[1] = 7'd7; rd_idx[2] = 7'd12;
        wr_en[0] = 1'b1; wr_idx[0] = 7'd50; wr_data[0] = 64'h77;
        alloc_vld[0] = 1'b1; alloc_idx[0] = 7'd51;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cnt0 !== 7'd96) begin failures++; $display("FAIL async_rst_cnt got=%0d exp=96", cnt0); end
        tick();
        clear_inputs();
        rd_idx[0] = 7'd50; rd_idx[1] = 7'd7; rd_idx[2] = 7'd12;
        #2 rst_n = 1'b1;
        tick();
        checks++; if (rd_data0[0] !== 64'd0 || rd_ready0[0] !== 1'b1) begin failures++; $display("FAIL rst_write_lost got=%h/%b exp=0/1", rd_data0[0], rd_ready0[0]); end
        checks++; if (rd_data0[1] !== 64'd0) begin failures++; $display("FAIL rst_data_clear got=%h exp=0", rd_data0[1]); end
        checks++; if (rd_ready0[2] !== 1'b1) begin failures++; $display("FAIL rst_ready_set got=%b exp=1", rd_ready0[2]); end
        checks++; if (cnt0 !== 7'd96 || cnt1 !== 7'd96) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=96/96", cnt0, cnt1); end
    endtask

    initial begin
        test_reset();
        test_alloc_write();
        test_collision();
        test_entry0();
        test_alloc_write_same();
        test_dup_alloc_range();
        test_bypass();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
